// File: rtl/pause_ce_gate.sv
// rtl/pause_ce_gate.sv - CPU clock-enable gate that freezes the core at an opcode boundary on request.
// Also supports single-frame stepping while frozen and a drain timeout that forces the stop.
module pause_ce_gate #(
  parameter int TIMEOUT_CE = 64,
  parameter int CW         = $clog2(TIMEOUT_CE + 1)
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pause_cpu,
  input  logic step_frame,
  input  logic ce_in,
  input  logic cpu_sync,
  input  logic vblank,
  output logic ce_out,
  output logic paused,
  output logic forced
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_PAUSED = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          paused_q;
  logic          forced_q, forced_d;
  logic          step_last_q;
  logic          vblank_last_q;
  logic          ce_gated;

  logic step_rise;
  logic vblank_rise;
  logic at_max;
  logic freeze_now;

  assign step_rise   = step_frame & ~step_last_q;
  assign vblank_rise = vblank & ~vblank_last_q;
  assign at_max      = (cnt_q == CNT_MAX);
  // The pulse that carries us into PAUSED is swallowed; a withdrawn request lets it through.
  assign freeze_now  = pause_cpu & ce_in & (cpu_sync | at_max);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    forced_d = forced_q;
    ce_gated = 1'b0;
    case (state_q)
      S_RUN: begin
        ce_gated = ce_in;
        if (pause_cpu) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        ce_gated = ce_in & ~freeze_now;
        if (!pause_cpu) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (ce_in && cpu_sync) begin
          state_d  = S_PAUSED;
          forced_d = 1'b0;
        end else if (ce_in && at_max) begin
          state_d  = S_PAUSED;
          forced_d = 1'b1;
        end else if (ce_in) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PAUSED: begin
        if (!pause_cpu) begin
          state_d  = S_RUN;
          forced_d = 1'b0;
        end else if (step_rise) begin
          state_d  = S_STEP;
          forced_d = 1'b0;
        end
      end
      S_STEP: begin
        ce_gated = ce_in;
        if (!pause_cpu) begin
          state_d = S_RUN;
        end else if (vblank_rise) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d  = S_RUN;
        cnt_d    = '0;
        forced_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      cnt_q         <= '0;
      paused_q      <= 1'b0;
      forced_q      <= 1'b0;
      step_last_q   <= 1'b0;
      vblank_last_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paused_q      <= (state_d == S_PAUSED);
      forced_q      <= forced_d;
      step_last_q   <= step_frame;
      vblank_last_q <= vblank;
    end
  end

  assign ce_out = reset_n & ce_gated;
  assign paused = paused_q;
  assign forced = forced_q;

endmodule

// File: tb/tb_pause_ce_gate.sv
// tb/tb_pause_ce_gate.sv - randomized and directed bench for pause_ce_gate against a behavioural model.
module tb_pause_ce_gate;

  localparam int TO = 8;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic pause_cpu = 1'b0;
  logic step_frame = 1'b0;
  logic ce_in = 1'b0;
  logic cpu_sync = 1'b0;
  logic vblank = 1'b0;
  logic ce_out, paused, forced;

  int n_tests = 0;
  int n_fail  = 0;

  pause_ce_gate #(.TIMEOUT_CE(TO)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .pause_cpu (pause_cpu),
    .step_frame(step_frame),
    .ce_in     (ce_in),
    .cpu_sync  (cpu_sync),
    .vblank    (vblank),
    .ce_out    (ce_out),
    .paused    (paused),
    .forced    (forced)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the CPU is doing (running, draining toward a stop,
  // frozen, or stepping a frame) plus how many enables it has consumed while draining.
  localparam int M_RUN = 0, M_DRAIN = 1, M_FROZEN = 2, M_STEP = 3;
  int m_mode;
  int m_seen;
  bit m_forced;
  bit m_prev_step, m_prev_vb;

  function automatic bit m_enters_freeze();
    return (m_mode == M_DRAIN) && pause_cpu && ce_in && (cpu_sync || m_seen == TO - 1);
  endfunction

  function automatic bit exp_ce();
    if (!reset_n || m_mode == M_FROZEN || m_enters_freeze()) return 1'b0;
    return ce_in;
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_mode      <= M_RUN;
      m_seen      <= 0;
      m_forced    <= 1'b0;
      m_prev_step <= 1'b0;
      m_prev_vb   <= 1'b0;
    end else begin
      m_prev_step <= step_frame;
      m_prev_vb   <= vblank;
      if (!pause_cpu) begin
        if (m_mode != M_RUN) m_seen <= (m_mode == M_DRAIN) ? 0 : m_seen;
        m_mode   <= M_RUN;
        m_forced <= 1'b0;
      end else if (m_mode == M_RUN) begin
        m_mode <= M_DRAIN;
        m_seen <= 0;
      end else if (m_mode == M_DRAIN && ce_in) begin
        if (m_enters_freeze()) begin
          m_mode   <= M_FROZEN;
          m_forced <= !cpu_sync;
        end else begin
          m_seen <= m_seen + 1;
        end
      end else if (m_mode == M_FROZEN && step_frame && !m_prev_step) begin
        m_mode   <= M_STEP;
        m_forced <= 1'b0;
      end else if (m_mode == M_STEP && vblank && !m_prev_vb) begin
        m_mode <= M_DRAIN;
        m_seen <= 0;
      end
    end
  end

  always @(negedge clk_sys) begin
    chk("ce_out_model", ce_out, exp_ce());
    chk("paused_model", paused, m_mode == M_FROZEN);
    chk("forced_model", forced, m_forced);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pause_cpu = 0; step_frame = 0; ce_in = 1; cpu_sync = 0; vblank = 0;
    #1;
    chk("reset_ce_out", ce_out, 0);
    chk("reset_paused", paused, 0);
    chk("reset_forced", forced, 0);
    tick();
    reset_n = 1'b1;
    ce_in = 0;
    tick();
  endtask

  int passed;
  int mism;

  initial begin
    do_reset();

    // clean pause at a sync boundary
    pause_cpu = 1; ce_in = 0;
    tick();
    passed = 0;
    for (int p = 1; p <= 3; p++) begin
      repeat (3) begin ce_in = 0; cpu_sync = 0; tick(); end
      ce_in = 1; cpu_sync = (p == 3);
      #1;
      if (ce_out) passed++;
      if (p == 3) chk("clean_3rd_suppressed", ce_out, 0);
      chk("clean_not_yet_paused", paused, 0);
      tick();
    end
    ce_in = 0; cpu_sync = 0;
    chk("clean_passed", passed, 2);
    chk("clean_paused", paused, 1);
    chk("clean_forced", forced, 0);

    // timeout forces the pause
    do_reset();
    pause_cpu = 1; ce_in = 1; cpu_sync = 0;
    #1;
    chk("to_request_cycle_passes", ce_out, 1);
    tick();
    passed = 0;
    for (int i = 0; i < TO; i++) begin
      #1;
      if (ce_out) passed++;
      if (i == TO - 1) chk("to_last_suppressed", ce_out, 0);
      tick();
    end
    chk("to_passed", passed, TO - 1);
    chk("to_paused", paused, 1);
    chk("to_forced", forced, 1);
    pause_cpu = 0;
    tick();
    #1;
    chk("to_resume_paused", paused, 0);
    chk("to_resume_forced", forced, 0);
    chk("to_resume_ce", ce_out, 1);

    // frame step
    pause_cpu = 1; ce_in = 0;
    tick();
    ce_in = 1; cpu_sync = 1;
    tick();
    ce_in = 0; cpu_sync = 0;
    chk("fs_paused", paused, 1);
    step_frame = 1;
    tick();
    step_frame = 0;
    chk("fs_step_unpaused", paused, 0);
    mism = 0;
    for (int i = 0; i < 1000; i++) begin
      ce_in = (i % 4 == 0);
      #1;
      if (ce_out !== ce_in) mism++;
      tick();
    end
    chk("fs_ce_follows", mism, 0);
    vblank = 1; ce_in = 0;
    tick();
    vblank = 0;
    passed = 0;
    for (int p = 1; p <= 5; p++) begin
      repeat (3) begin ce_in = 0; cpu_sync = 0; tick(); end
      ce_in = 1; cpu_sync = (p == 5);
      #1;
      if (ce_out) passed++;
      tick();
    end
    ce_in = 0; cpu_sync = 0;
    chk("fs_drain_passed", passed, 4);
    chk("fs_repaused", paused, 1);
    chk("fs_forced", forced, 0);

    // STEP: pause drop wins over a vblank edge
    step_frame = 1;
    tick();
    step_frame = 0;
    tick();
    pause_cpu = 0; vblank = 1;
    tick();
    vblank = 0; pause_cpu = 1; ce_in = 1; cpu_sync = 1;
    #1;
    chk("sim_step_to_run_ce", ce_out, 1);
    tick();
    chk("sim_step_not_paused", paused, 0);
    // DRAIN: pause drop wins over a sync pulse, which passes
    pause_cpu = 0; ce_in = 1; cpu_sync = 1;
    #1;
    chk("sim_drain_drop_ce", ce_out, 1);
    tick();
    chk("sim_drain_drop_paused", paused, 0);
    ce_in = 0; cpu_sync = 0;

    // async reset while force-paused
    pause_cpu = 1; ce_in = 1; cpu_sync = 0;
    repeat (TO + 1) tick();
    chk("ar_paused_before", paused, 1);
    chk("ar_forced_before", forced, 1);
    #3;
    reset_n = 0;
    #1;
    chk("ar_paused", paused, 0);
    chk("ar_forced", forced, 0);
    chk("ar_ce_out", ce_out, 0);
    tick();
    reset_n = 1; ce_in = 1; cpu_sync = 1;
    #1;
    chk("ar_run_ce", ce_out, 1);
    tick();
    chk("ar_run_paused", paused, 0);
    pause_cpu = 0; ce_in = 0; cpu_sync = 0;
    tick();

    // step edge outside PAUSED is ignored
    do_reset();
    step_frame = 1;
    tick();
    step_frame = 0;
    tick();
    pause_cpu = 1; ce_in = 1; cpu_sync = 1;
    tick();
    tick();
    ce_in = 0; cpu_sync = 0;
    repeat (5) tick();
    chk("ign_still_paused", paused, 1);

    // randomized run, checked every cycle by the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) pause_cpu = ~pause_cpu;
      if ($urandom_range(0, 39) == 0) step_frame = ~step_frame;
      if ($urandom_range(0, 29) == 0) vblank = ~vblank;
      ce_in    = (i % 1000 < 200) ? 1'b1 : ($urandom_range(0, 2) == 0);
      cpu_sync = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        #2;
        reset_n = 0;
        tick();
        reset_n = 1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
